// File: rtl/memtrace_record_serializer.sv
// Serializes captured memory requests into a byte-wide valid/ready trace stream, one record per request.
// Defining MEMTRACE_TIMESTAMP_EN adds a 4-byte accept-cycle timestamp after the header.
module memtrace_record_serializer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LANE_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [1:0]        req_size,
  input  logic [LANE_W-1:0] req_lane,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              trace_write_valid,
  input  logic              trace_write_ready,
  output logic [7:0]        trace_write_bits,
  output logic [31:0]       records_emitted
);

  localparam int ADDR_BYTES = ADDR_W / 8;
  localparam int DATA_BYTES = DATA_W / 8;
  localparam int TS_BYTES   = 4;
  localparam int MAX_AD     = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int MAX_BYTES  = (MAX_AD > TS_BYTES) ? MAX_AD : TS_BYTES;
  localparam int IDX_W      = $clog2(MAX_BYTES + 1);

  // Data field length is 1<<size, clamped to the data bus width.
  localparam int SZ1 = (DATA_BYTES < 2) ? DATA_BYTES : 2;
  localparam int SZ2 = (DATA_BYTES < 4) ? DATA_BYTES : 4;
  localparam int SZ3 = (DATA_BYTES < 8) ? DATA_BYTES : 8;

  localparam logic [IDX_W-1:0] ADDR_LAST = IDX_W'(ADDR_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_TS,
    S_ADDR,
    S_DATA
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  byte_idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic [IDX_W-1:0]  data_last;
  logic              last_byte;
  logic              accept;

  logic              rec_is_store;
  logic [1:0]        rec_size;
  logic [LANE_W-1:0] rec_lane;
  logic [ADDR_W-1:0] rec_addr;
  logic [DATA_W-1:0] rec_data;
  logic [ADDR_W-1:0] addr_shift;
  logic [DATA_W-1:0] data_shift;

`ifdef MEMTRACE_TIMESTAMP_EN
  localparam logic [IDX_W-1:0] TS_LAST = IDX_W'(TS_BYTES - 1);

  logic [31:0] ts_count;
  logic [31:0] rec_ts;
  logic [31:0] ts_shift;

  always_ff @(posedge clock) begin
    if (!reset) begin
      ts_count <= 32'd0;
      rec_ts   <= 32'd0;
    end else begin
      ts_count <= ts_count + 32'd1;
      if (accept) rec_ts <= ts_count;
    end
  end

  assign ts_shift = rec_ts >> {byte_idx, 3'b000};
`endif

  assign addr_shift = rec_addr >> {byte_idx, 3'b000};
  assign data_shift = rec_data >> {byte_idx, 3'b000};

  always_comb begin
    data_last = '0;
    case (rec_size)
      2'd0:    data_last = '0;
      2'd1:    data_last = IDX_W'(SZ1 - 1);
      2'd2:    data_last = IDX_W'(SZ2 - 1);
      default: data_last = IDX_W'(SZ3 - 1);
    endcase
  end

  // Final byte of a record: end of ADDR for loads, end of DATA for stores.
  always_comb begin
    last_byte = 1'b0;
    if (state == S_ADDR)
      last_byte = !rec_is_store && (byte_idx == ADDR_LAST);
    else if (state == S_DATA)
      last_byte = (byte_idx == data_last);
  end

  assign req_ready         = reset && ((state == S_IDLE) || (last_byte && trace_write_ready));
  assign accept            = req_valid && req_ready;
  assign trace_write_valid = (state != S_IDLE);

  always_comb begin
    state_nxt        = state;
    idx_nxt          = byte_idx;
    trace_write_bits = 8'h00;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_HDR;
          idx_nxt   = '0;
        end
      end
      S_HDR: begin
        trace_write_bits = {1'b1, rec_is_store, rec_size, 4'(rec_lane)};
        if (trace_write_ready) begin
`ifdef MEMTRACE_TIMESTAMP_EN
          state_nxt = S_TS;
`else
          state_nxt = S_ADDR;
`endif
          idx_nxt = '0;
        end
      end
`ifdef MEMTRACE_TIMESTAMP_EN
      S_TS: begin
        trace_write_bits = ts_shift[7:0];
        if (trace_write_ready) begin
          if (byte_idx == TS_LAST) begin
            state_nxt = S_ADDR;
            idx_nxt   = '0;
          end else begin
            idx_nxt = byte_idx + IDX_W'(1);
          end
        end
      end
`endif
      S_ADDR: begin
        trace_write_bits = addr_shift[7:0];
        if (trace_write_ready) begin
          if (byte_idx != ADDR_LAST) begin
            idx_nxt = byte_idx + IDX_W'(1);
          end else if (rec_is_store) begin
            state_nxt = S_DATA;
            idx_nxt   = '0;
          end else begin
            state_nxt = accept ? S_HDR : S_IDLE;
            idx_nxt   = '0;
          end
        end
      end
      S_DATA: begin
        trace_write_bits = data_shift[7:0];
        if (trace_write_ready) begin
          if (byte_idx != data_last) begin
            idx_nxt = byte_idx + IDX_W'(1);
          end else begin
            state_nxt = accept ? S_HDR : S_IDLE;
            idx_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Record register only loads on accept, which never overlaps a byte still owed from it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state           <= S_IDLE;
      byte_idx        <= '0;
      rec_is_store    <= 1'b0;
      rec_size        <= 2'd0;
      rec_lane        <= '0;
      rec_addr        <= '0;
      rec_data        <= '0;
      records_emitted <= 32'd0;
    end else begin
      state    <= state_nxt;
      byte_idx <= idx_nxt;
      if (accept) begin
        rec_is_store <= req_is_store;
        rec_size     <= req_size;
        rec_lane     <= req_lane;
        rec_addr     <= req_addr;
        rec_data     <= req_data;
      end
      if (last_byte && trace_write_ready)
        records_emitted <= records_emitted + 32'd1;
    end
  end

endmodule

// File: tb/tb_memtrace_record_serializer.sv
// Directed bench for memtrace_record_serializer in its default build (no timestamp field).
module tb_memtrace_record_serializer;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [1:0]  req_size;
  logic [3:0]  req_lane;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        trace_write_valid;
  logic        trace_write_ready;
  logic [7:0]  trace_write_bits;
  logic [31:0] records_emitted;

  int checks = 0;
  int fails  = 0;

  logic [7:0] stall_bytes [5] = '{8'hA7, 8'h88, 8'h77, 8'h66, 8'h55};

  memtrace_record_serializer #(
    .ADDR_W(32),
    .DATA_W(32),
    .LANE_W(4)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_is_store     (req_is_store),
    .req_size         (req_size),
    .req_lane         (req_lane),
    .req_addr         (req_addr),
    .req_data         (req_data),
    .trace_write_valid(trace_write_valid),
    .trace_write_ready(trace_write_ready),
    .trace_write_bits (trace_write_bits),
    .records_emitted  (records_emitted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic nextCycle();
    @(posedge clock);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic [3:0] ln,
                               input logic [31:0] ad, input logic [31:0] dt);
    req_valid    = 1'b1;
    req_is_store = st;
    req_size     = sz;
    req_lane     = ln;
    req_addr     = ad;
    req_data     = dt;
  endtask

  task automatic expectByte(input string tag, input logic [7:0] exp_byte);
    checkOutput({tag, "_valid"}, 32'(trace_write_valid), 32'd1);
    checkOutput({tag, "_bits"}, 32'(trace_write_bits), 32'(exp_byte));
    nextCycle();
  endtask

  initial begin
    reset             = 1'b0;
    req_valid         = 1'b0;
    req_is_store      = 1'b0;
    req_size          = 2'd0;
    req_lane          = 4'd0;
    req_addr          = 32'd0;
    req_data          = 32'd0;
    trace_write_ready = 1'b1;

    // Reset state
    repeat (3) nextCycle();
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_valid", 32'(trace_write_valid), 32'd0);
    checkOutput("rst_bits", 32'(trace_write_bits), 32'd0);
    checkOutput("rst_count", records_emitted, 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Load, lane 3, size 2
    applyStimulus(1'b0, 2'd2, 4'd3, 32'h8000_1234, 32'h0);
    #1;
    checkOutput("ld_accept_ready", 32'(req_ready), 32'd1);
    nextCycle();
    req_valid = 1'b0;
    #1;
    expectByte("ld_hdr", 8'hA3);
    expectByte("ld_a0", 8'h34);
    expectByte("ld_a1", 8'h12);
    expectByte("ld_a2", 8'h00);
    checkOutput("ld_last_req_ready", 32'(req_ready), 32'd1);
    expectByte("ld_a3", 8'h80);
    checkOutput("ld_idle_valid", 32'(trace_write_valid), 32'd0);
    checkOutput("ld_count", records_emitted, 32'd1);

    // Store, lane 0, size 1
    applyStimulus(1'b1, 2'd1, 4'd0, 32'h0000_0010, 32'hDEAD_BEEF);
    nextCycle();
    req_valid = 1'b0;
    #1;
    expectByte("st_hdr", 8'hD0);
    expectByte("st_a0", 8'h10);
    expectByte("st_a1", 8'h00);
    checkOutput("st_mid_req_ready", 32'(req_ready), 32'd0);
    expectByte("st_a2", 8'h00);
    expectByte("st_a3", 8'h00);
    expectByte("st_d0", 8'hEF);
    expectByte("st_d1", 8'hBE);
    checkOutput("st_idle_valid", 32'(trace_write_valid), 32'd0);
    checkOutput("st_count", records_emitted, 32'd2);

    // Store size 3 on a 32-bit data bus clamps to 4 data bytes
    applyStimulus(1'b1, 2'd3, 4'd5, 32'h0000_0004, 32'h1122_3344);
    nextCycle();
    req_valid = 1'b0;
    #1;
    expectByte("st8_hdr", 8'hF5);
    expectByte("st8_a0", 8'h04);
    expectByte("st8_a1", 8'h00);
    expectByte("st8_a2", 8'h00);
    expectByte("st8_a3", 8'h00);
    expectByte("st8_d0", 8'h44);
    expectByte("st8_d1", 8'h33);
    expectByte("st8_d2", 8'h22);
    expectByte("st8_d3", 8'h11);
    checkOutput("st8_idle_valid", 32'(trace_write_valid), 32'd0);
    checkOutput("st8_count", records_emitted, 32'd3);

    // Two loads back-to-back with request held valid
    applyStimulus(1'b0, 2'd0, 4'd1, 32'hA0B0_C0D0, 32'h0);
    nextCycle();
    expectByte("b2b1_hdr", 8'h81);
    checkOutput("b2b1_busy_req_ready", 32'(req_ready), 32'd0);
    expectByte("b2b1_a0", 8'hD0);
    expectByte("b2b1_a1", 8'hC0);
    expectByte("b2b1_a2", 8'hB0);
    checkOutput("b2b1_last_req_ready", 32'(req_ready), 32'd1);
    applyStimulus(1'b0, 2'd1, 4'd2, 32'h0102_0304, 32'h0);
    #1;
    expectByte("b2b1_a3", 8'hA0);
    req_valid = 1'b0;
    #1;
    checkOutput("b2b1_count", records_emitted, 32'd4);
    expectByte("b2b2_hdr", 8'h92);
    expectByte("b2b2_a0", 8'h04);
    expectByte("b2b2_a1", 8'h03);
    expectByte("b2b2_a2", 8'h02);
    expectByte("b2b2_a3", 8'h01);
    checkOutput("b2b2_idle_valid", 32'(trace_write_valid), 32'd0);
    checkOutput("b2b2_count", records_emitted, 32'd5);

    // Sink ready toggled: bytes held stable while stalled
    applyStimulus(1'b0, 2'd2, 4'd7, 32'h5566_7788, 32'h0);
    nextCycle();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      trace_write_ready = 1'b0;
      #1;
      checkOutput("stall_bits", 32'(trace_write_bits), 32'(stall_bytes[i]));
      nextCycle();
      checkOutput("stall_hold_valid", 32'(trace_write_valid), 32'd1);
      checkOutput("stall_hold_bits", 32'(trace_write_bits), 32'(stall_bytes[i]));
      if (i == 4) checkOutput("stall_last_req_ready_low", 32'(req_ready), 32'd0);
      trace_write_ready = 1'b1;
      #1;
      if (i == 4) checkOutput("stall_last_req_ready_high", 32'(req_ready), 32'd1);
      nextCycle();
    end
    checkOutput("stall_idle_valid", 32'(trace_write_valid), 32'd0);
    checkOutput("stall_count", records_emitted, 32'd6);

    // Reset in the middle of a store discards it
    applyStimulus(1'b1, 2'd2, 4'd0, 32'h1234_5678, 32'hCAFE_F00D);
    nextCycle();
    req_valid = 1'b0;
    #1;
    expectByte("rs_hdr", 8'hE0);
    expectByte("rs_a0", 8'h78);
    reset = 1'b0;
    #1;
    checkOutput("rs_req_ready", 32'(req_ready), 32'd0);
    nextCycle();
    checkOutput("rs_valid", 32'(trace_write_valid), 32'd0);
    checkOutput("rs_bits", 32'(trace_write_bits), 32'd0);
    checkOutput("rs_count", records_emitted, 32'd0);
    nextCycle();
    reset = 1'b1;
    applyStimulus(1'b0, 2'd0, 4'd1, 32'h0000_0009, 32'h0);
    nextCycle();
    req_valid = 1'b0;
    #1;
    expectByte("rs_new_hdr", 8'h81);
    expectByte("rs_new_a0", 8'h09);
    expectByte("rs_new_a1", 8'h00);
    expectByte("rs_new_a2", 8'h00);
    expectByte("rs_new_a3", 8'h00);
    checkOutput("rs_new_idle_valid", 32'(trace_write_valid), 32'd0);
    checkOutput("rs_new_count", records_emitted, 32'd1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
